// File: rtl/bin7seg_pkg.sv
// Shared segment types, levels and the hex-to-segment table for the display driver.
package bin7seg_pkg;

    // Segment vector ordered {g,f,e,d,c,b,a}, active-high inside the core.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;
    localparam seg_t SEG_ON  = 7'h7F;

    // Hex nibble to active-high segment pattern.
    function automatic seg_t hex2seg(input logic [3:0] hex);
        seg_t seg;
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = SEG_ON;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble decoder producing active-high segments.
module hex_to_7seg
    import bin7seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg_c
);

    // Table lookup lives in the package so other blocks can reuse it.
    assign seg_c = hex2seg(hex);

endmodule

// File: rtl/bin_to_7seg_mux.sv
// Time-multiplexed N-digit hex display driver with frame-aligned double buffering.
module bin_to_7seg_mux
    import bin7seg_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned REFRESH_HZ     = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    reloj,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   valor_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
    input  logic                    enable_i,
    output seg_t                    seg_o,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     an_o,
    output logic                    frame_o
);

    localparam int unsigned DIV_RAW = CLK_FREQ_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W   = 4 * N_DIGITS;

    localparam seg_t                SEG_PIN_OFF = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_PIN_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_PIN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic [IDX_W-1:0]    idx;
    logic                last_digit;
    logic                boundary;

    logic [VAL_W-1:0]    act_val;
    logic [N_DIGITS-1:0] act_dp;
    logic [VAL_W-1:0]    pend_val;
    logic [N_DIGITS-1:0] pend_dp;
    logic                pend_flag;

    logic [3:0]          nibble;
    logic                dp_sel;
    logic                blank_c;
    seg_t                dec_seg;

    seg_t                seg_nxt;
    logic                dp_nxt;
    logic [N_DIGITS-1:0] an_nxt;

    assign tick       = (cnt == CNT_W'(DIV - 1));
    assign last_digit = (idx == IDX_W'(N_DIGITS - 1));
    assign boundary   = tick && last_digit;

    // Refresh divider: one tick per digit slot.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Scan index advances on each tick and wraps at the last digit.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= last_digit ? '0 : idx + IDX_W'(1);
        end
    end

    // Double buffer: loads land in pending, which is promoted only at a frame boundary.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            act_val   <= '0;
            act_dp    <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (boundary && pend_flag) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            if (load_i) begin
                pend_val  <= valor_i;
                pend_dp   <= dp_i;
                pend_flag <= 1'b1;
            end else if (boundary) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // Select the nibble and decimal point for the digit being scanned.
    assign nibble = 4'(act_val >> {idx, 2'b00});
    assign dp_sel = 1'(act_dp >> idx);

    // A digit above 0 is blanked when it and every more significant nibble are zero.
    assign blank_c = blank_lz_i && (idx != '0) && ((act_val >> {idx, 2'b00}) == '0);

    hex_to_7seg u_dec (
        .hex   (nibble),
        .seg_c (dec_seg)
    );

    // Next pin levels: everything off unless enabled, polarity folded in here.
    always_comb begin
        seg_nxt = SEG_PIN_OFF;
        dp_nxt  = DP_PIN_OFF;
        an_nxt  = AN_PIN_OFF;
        if (enable_i) begin
            seg_nxt = (blank_c ? SEG_OFF : dec_seg) ^ {7{SEG_ACTIVE_LOW}};
            dp_nxt  = dp_sel ^ SEG_ACTIVE_LOW;
            an_nxt  = (N_DIGITS'(1) << idx) ^ {N_DIGITS{AN_ACTIVE_LOW}};
        end
    end

    // Pin registers, one cycle behind the scan index.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= SEG_PIN_OFF;
            dp_o  <= DP_PIN_OFF;
            an_o  <= AN_PIN_OFF;
        end else begin
            seg_o <= seg_nxt;
            dp_o  <= dp_nxt;
            an_o  <= an_nxt;
        end
    end

    // Frame pulse marks the cycle following the boundary edge.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            frame_o <= 1'b0;
        end else begin
            frame_o <= boundary;
        end
    end

endmodule

// File: tb/tb_bin_to_7seg_mux.sv
// Scoreboard bench for bin_to_7seg_mux: a cycle-count based model queues expected pins.
module tb_bin_to_7seg_mux;

    localparam int N     = 4;
    localparam int DIV   = 5;
    localparam int FRAME = DIV * N;

    logic        reloj;
    logic        rst_n;
    logic [15:0] valor_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        blank_lz_i;
    logic        enable_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks;
    int         n_fail;
    int         edge_n;
    logic [6:0] seg_tab [16];

    bin_to_7seg_mux #(
        .N_DIGITS       (N),
        .CLK_FREQ_HZ    (1000),
        .REFRESH_HZ     (50),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .reloj      (reloj),
        .rst_n      (rst_n),
        .valor_i    (valor_i),
        .dp_i       (dp_i),
        .load_i     (load_i),
        .blank_lz_i (blank_lz_i),
        .enable_i   (enable_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digit slot and frame position follow directly from the edge count.
    initial begin
        logic [15:0] m_act, m_pend;
        logic [3:0]  m_adp, m_pdp, nib;
        logic        m_pflag, bnd;
        logic [6:0]  hi;
        int          digit;
        exp_t        e;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pflag = 1'b0;
        edge_n = 0;
        forever begin
            @(posedge reloj);
            if (!rst_n) begin
                m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pflag = 1'b0;
                edge_n = 0;
                e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, frame: 1'b0};
            end else begin
                digit = (edge_n / DIV) % N;
                bnd   = ((edge_n % FRAME) == FRAME - 1);
                if (enable_i) begin
                    nib = 4'(m_act >> (4 * digit));
                    if (blank_lz_i && digit > 0 && (m_act >> (4 * digit)) == 16'h0)
                        hi = 7'h00;
                    else
                        hi = seg_tab[nib];
                    e.seg = ~hi;
                    e.dp  = ~m_adp[digit];
                    e.an  = ~(4'b0001 << digit);
                end else begin
                    e.seg = 7'h7F;
                    e.dp  = 1'b1;
                    e.an  = 4'hF;
                end
                e.frame = bnd;
                if (bnd && m_pflag) begin
                    m_act   = m_pend;
                    m_adp   = m_pdp;
                    m_pflag = 1'b0;
                end
                if (load_i) begin
                    m_pend  = valor_i;
                    m_pdp   = dp_i;
                    m_pflag = 1'b1;
                end
                edge_n++;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the registered pins against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge reloj);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_o",   8'(seg_o),   8'(e.seg));
                check("dp_o",    8'(dp_o),    8'(e.dp));
                check("an_o",    8'(an_o),    8'(e.an));
                check("frame_o", 8'(frame_o), 8'(e.frame));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge reloj);
    endtask

    // Stop at the negedge just before the edge with the given frame position.
    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            @(negedge reloj);
            if ((edge_n % FRAME) == ph) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_phase: phase %0d never reached", ph);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        valor_i = v;
        dp_i    = d;
        load_i  = 1'b1;
        @(negedge reloj);
        load_i  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        valor_i    = '0;
        dp_i       = '0;
        load_i     = 1'b0;
        blank_lz_i = 1'b0;
        enable_i   = 1'b1;
        n_checks   = 0;
        n_fail     = 0;

        cycles(3);
        rst_n = 1'b1;
        cycles(45);

        // Mid-frame load becomes visible only after the next boundary.
        wait_phase(7);
        pulse_load(16'h1A2F, 4'b0100);
        cycles(50);

        // Leading-zero blanking.
        blank_lz_i = 1'b1;
        wait_phase(3);
        pulse_load(16'h0030, 4'b0000);
        cycles(45);
        pulse_load(16'h0000, 4'b0010);
        cycles(45);
        blank_lz_i = 1'b0;

        // Second load coincident with the boundary tick.
        wait_phase(10);
        pulse_load(16'h1111, 4'b0001);
        wait_phase(FRAME - 1);
        pulse_load(16'h2222, 4'b1000);
        cycles(45);

        // Display disabled while the scan keeps running.
        enable_i = 1'b0;
        cycles(30);
        enable_i = 1'b1;
        cycles(25);

        // Randomized loads, blanking and enable.
        for (int i = 0; i < 300; i++) begin
            @(negedge reloj);
            valor_i    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_i       = 4'($urandom);
            load_i     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz_i = ~blank_lz_i;
            enable_i   = ($urandom_range(0, 15) != 0);
        end
        @(negedge reloj);
        load_i     = 1'b0;
        enable_i   = 1'b1;
        blank_lz_i = 1'b0;
        cycles(25);

        // Asynchronous reset with a load pending: pins go off without a clock edge.
        wait_phase(5);
        pulse_load(16'hBEEF, 4'b1111);
        cycles(3);
        #1 rst_n = 1'b0;
        #1;
        check("async_seg_o",   8'(seg_o),   8'h7F);
        check("async_dp_o",    8'(dp_o),    8'h01);
        check("async_an_o",    8'(an_o),    8'h0F);
        check("async_frame_o", 8'(frame_o), 8'h00);
        cycles(2);
        rst_n = 1'b1;
        cycles(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_7seg_mux.md
Name: bin_to_7seg_mux

Overview:
- Parametrised, time-multiplexed N-digit hexadecimal 7-segment display driver.
- Successor to the single-digit binary-to-7-segment decoder.
- Adds digit scanning, a refresh divider, leading-zero blanking and per-digit decimal points.
- Adds tear-free value updates: a new value is double-buffered and takes effect only at a frame boundary.
- Sits between the Gray decoder datapath and the board's common-anode display pins.

Parameters:
- N_DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_FREQ_HZ, 100_000_000: frequency of reloj.
- REFRESH_HZ, 1000: full-frame refresh rate.
- DIV: derived constant = max(1, CLK_FREQ_HZ/(REFRESH_HZ*N_DIGITS)); clocks per digit slot.
- SEG_ACTIVE_LOW, 1: 1 means seg_o and dp_o are inverted at the pins.
- AN_ACTIVE_LOW, 1: 1 means an_o is inverted at the pins.

Ports:
- reloj  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valor_i  in  4*N_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant (rightmost).
- dp_i  in  N_DIGITS  decimal-point request per digit.
- load_i  in  1  one-cycle strobe; captures valor_i and dp_i into the pending buffer.
- blank_lz_i  in  1  enable leading-zero blanking.
- enable_i  in  1  0 blanks the whole display.
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal-point segment.
- an_o  out  N_DIGITS  digit anode selects.
- frame_o  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, sync release): div counter=0, idx=0, active and pending buffers=0, pend_flag=0, frame_o=0. All outputs at the off level: seg_o=7'h7F, dp_o=1, an_o=all 1s (for the default active-low parameters).
- Divider: counts 0..DIV-1 and raises tick when count==DIV-1, then wraps to 0. With DIV=1, tick is asserted every cycle.
- Scan index:
  - On tick, idx increments.
  - At idx==N_DIGITS-1 a tick wraps idx to 0 and is a frame boundary.
  - N_DIGITS=1: every tick is a frame boundary.
- Load:
  - load_i=1 writes valor_i/dp_i into pending and sets pend_flag.
  - A repeated load before the boundary overwrites pending (last write wins).
- Frame boundary:
  - If pend_flag=1, active<=pending and pend_flag clears, in the same edge.
  - frame_o=1 for exactly that cycle.
- Load coincident with boundary: active takes the pending contents held before this edge (only if pend_flag was already set). The new load lands in pending, pend_flag stays 1, and it applies at the next boundary.
- Decode: nibble to active-high segments.
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Inversion applied per SEG_ACTIVE_LOW.
- Leading-zero blanking: with blank_lz_i=1, digit i>0 is blanked when active nibbles N_DIGITS-1..i are all zero. Digit 0 is never blanked. A blanked digit has segments off but anode still asserted, and dp_o still follows dp_i[i].
- Output registers:
  - seg_o, dp_o and an_o are registered from the current idx and active buffer, so outputs lag idx by one cycle.
  - Exactly one anode is asserted when enable_i=1.
  - When enable_i=0, all of seg_o/dp_o/an_o are off on the next cycle; divider, idx and loads keep running.
- Width rules: idx is $clog2(N_DIGITS) bits, minimum 1. The divider counter is $clog2(DIV) bits, minimum 1.
- Reset mid-frame: the pending value is lost and the display restarts at digit 0 with active=0.

Decomposition:
- Package bin7seg_pkg holds:
  - typedef seg_t (logic [6:0]);
  - the SEG_OFF/SEG_ON constants;
  - a function hex2seg(logic [3:0]) returning seg_t with the table above.
- Sub-module hex_to_7seg: combinational wrapper around hex2seg, instantiated once on the selected nibble.
- Top module holds the divider, scan index, double buffer, blanking logic and output registers.

Test Plan (CLK_FREQ_HZ=1000, REFRESH_HZ=50, N_DIGITS=4, so DIV=5):
- Reset released, no load, enable_i=1, blank_lz_i=0 -> an_o steps 1110, 1101, 1011, 0111 every 5 clocks. seg_o=7'h40 (zero) on each digit. frame_o pulses once every 20 clocks.
- load_i with valor_i=16'h1A2F, dp_i=4'b0100 mid-frame -> digits keep showing 0 until frame_o. From the frame after that:
  - digit0 seg_o=7'h0E (F);
  - digit1 seg_o=7'h24 (2), dp_o=1;
  - digit2 seg_o=7'h08 (A), dp_o=0;
  - digit3 seg_o=7'h79 (1).
- blank_lz_i=1, active=16'h0030 -> digits 3 and 2 seg_o=7'h7F, digit1 seg_o=7'h30 (3), digit0 seg_o=7'h40. With active=16'h0000, only digit0 is lit.
- Two loads (16'h1111 then 16'h2222) inside one frame, with the second coincident with the boundary tick:
  - that boundary applies 16'h1111;
  - the next boundary applies 16'h2222;
  - frame_o pulses at each boundary.
- enable_i=0 for 30 clocks -> an_o=4'hF, seg_o=7'h7F one cycle later. On re-enable, scanning resumes at the idx the divider reached, with no extra frame_o pulses.
- rst_n asserted asynchronously mid-digit with a load pending -> outputs off immediately without a clock edge. After release the display shows 0, and the pending value is never displayed.
